// File: rtl/io_test_pkg.sv
// io_test_pkg: state encodings, active-low RGB codes and the checker-pattern helper
package io_test_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0, WALK = 3'd1, CHECK_A = 3'd2, CHECK_B = 3'd3, ALL_ON = 3'd4, DONE = 3'd5
  } state_t;
  localparam logic [2:0] RGB_OFF = 3'b111;
  localparam logic [2:0] RGB_RED = 3'b110;
  localparam logic [2:0] RGB_GRN = 3'b101;
  localparam logic [2:0] RGB_BLU = 3'b011;
  localparam logic [2:0] RGB_WHT = 3'b000;
  localparam logic [2:0] RGB_YEL = 3'b100;
  function automatic logic checker_bit(input int pin, input logic odd);
    return (pin % 2 == 1) == odd;
  endfunction
endpackage

// File: rtl/io_test_dwell_timer.sv
// io_test_dwell_timer: counts enabled ticks and pulses step on the DWELL_TICKS-th one
module io_test_dwell_timer #(
  parameter int DWELL_TICKS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  logic [DW-1:0] cnt;
  assign step = en && cnt == DW'(DWELL_TICKS - 1);
  always_ff @(posedge clk) begin
    if (rst || clr || step) cnt <= '0;
    else if (en) cnt <= cnt + DW'(1);
  end
endmodule

// File: rtl/io_test_sequencer.sv
// io_test_sequencer: start/abort controlled walk/checker/all-on IO and LED test scheduler
// Optional IO_TEST_HOLD_EN adds a hold input that freezes the pattern while busy.
module io_test_sequencer
  import io_test_pkg::*;
#(
  parameter int NUM_PINS    = 20,
  parameter int DWELL_TICKS = 1,
  parameter int NUM_PASSES  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              tick,
`ifdef IO_TEST_HOLD_EN
  input  logic                              hold,
`endif
  output logic [NUM_PINS-1:0]               io_out,
  output logic [2:0]                        rgb_n,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NUM_PASSES+1)-1:0]   pass_cnt
);
  localparam int PW = $clog2(NUM_PASSES + 1);
  localparam int IW = $clog2(NUM_PINS);
  state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [PW-1:0] pass_d;
  logic [NUM_PINS-1:0] io_d, chk_a, chk_b;
  logic [2:0] rgb_d;
  logic step, busy_d, hold_in;
`ifdef IO_TEST_HOLD_EN
  assign hold_in = hold;
`else
  assign hold_in = 1'b0;
`endif
  io_test_dwell_timer #(.DWELL_TICKS(DWELL_TICKS)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (abort || !busy),
    .en  (tick && busy && !hold_in),
    .step(step)
  );
  always_comb begin
    for (int i = 0; i < NUM_PINS; i++) begin
      chk_a[i] = checker_bit(i, 1'b0);
      chk_b[i] = checker_bit(i, 1'b1);
    end
  end
  always_comb begin
    state_d = state;
    idx_d   = idx;
    pass_d  = pass_cnt;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (state == IDLE || state == DONE) begin
      if (start) begin
        state_d = WALK;
        idx_d   = '0;
        pass_d  = '0;
      end
    end else if (step) begin
      case (state)
        WALK: begin
          idx_d   = idx == IW'(NUM_PINS - 1) ? '0 : idx + 1'b1;
          state_d = idx == IW'(NUM_PINS - 1) ? CHECK_A : WALK;
        end
        CHECK_A: state_d = CHECK_B;
        CHECK_B: state_d = ALL_ON;
        ALL_ON: begin
          pass_d  = pass_cnt + 1'b1;
          state_d = pass_d == PW'(NUM_PASSES) ? DONE : WALK;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = state_d inside {WALK, CHECK_A, CHECK_B, ALL_ON};
    io_d   = state_d == WALK    ? NUM_PINS'(1) << idx_d :
             state_d == CHECK_A ? chk_a :
             state_d == CHECK_B ? chk_b :
             state_d == ALL_ON  ? '1 : '0;
    rgb_d  = (hold_in && busy_d)                      ? RGB_YEL :
             state_d == IDLE                          ? RGB_OFF :
             state_d == WALK                          ? RGB_RED :
             (state_d == CHECK_A || state_d == CHECK_B) ? RGB_GRN :
             state_d == ALL_ON                        ? RGB_BLU : RGB_WHT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      pass_cnt <= '0;
      io_out   <= '0;
      rgb_n    <= RGB_OFF;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      pass_cnt <= pass_d;
      io_out   <= io_d;
      rgb_n    <= rgb_d;
      busy     <= busy_d;
      done     <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_io_test_sequencer.sv
// tb_io_test_sequencer: directed literal checks plus a random run against a step-count model
module tb_io_test_sequencer;
  localparam int N = 20;
  localparam int D = 2;
  localparam int P = 2;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, tick = 1'b0;
  logic [N-1:0] io_out;
  logic [2:0] rgb_n;
  logic busy, done;
  logic [1:0] pass_cnt;
  int n_checks = 0, n_errors = 0;
  bit chk_en = 1'b0;
  // Model: mode 0 idle, 1 running, 2 done; pos = step within a pass (0..N+2)
  int m_mode = 0, m_pos = 0, m_dw = 0, m_pass = 0;

  io_test_sequencer #(.NUM_PINS(N), .DWELL_TICKS(D), .NUM_PASSES(P)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick),
`ifdef IO_TEST_HOLD_EN
    .hold(1'b0),
`endif
    .io_out(io_out), .rgb_n(rgb_n), .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] pat(int p);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++)
      v[i] = p < N ? (i == p) : p == N ? (i % 2 == 0) : p == N + 1 ? (i % 2 == 1) : 1'b1;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pos = 0; m_dw = 0; m_pass = 0;
    end else if (abort) m_mode = 0;
    else if (m_mode == 1) begin
      if (tick) begin
        if (m_dw == D - 1) begin
          m_dw = 0;
          if (m_pos == N + 2) begin
            m_pos = 0;
            m_pass++;
            if (m_pass == P) m_mode = 2;
          end else m_pos++;
        end else m_dw++;
      end
    end else if (start) begin
      m_mode = 1; m_pos = 0; m_dw = 0; m_pass = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model io_out", io_out, m_mode == 1 ? pat(m_pos) : '0);
      check("model rgb_n", rgb_n, m_mode == 0 ? 3'b111 : m_mode == 2 ? 3'b000 :
            m_pos < N ? 3'b110 : m_pos < N + 2 ? 3'b101 : 3'b011);
      check("model busy", busy, m_mode == 1);
      check("model done", done, m_mode == 2);
      check("model pass_cnt", pass_cnt, m_pass);
    end
  end

  task automatic drive(bit s, bit a, bit t);
    @(negedge clk);
    start = s; abort = a; tick = t;
  endtask

  task automatic one_tick(int gap);
    drive(0, 0, 1);
    repeat (gap) drive(0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) drive(0, 0, i % 2 == 0);
    drive(0, 0, 0);
    check("idle io_out", io_out, 0);
    check("idle rgb_n", rgb_n, 3'b111);
    check("idle busy", busy, 0);
    check("idle done", done, 0);
    check("idle pass_cnt", pass_cnt, 0);
    drive(1, 0, 0); drive(0, 0, 0);
    check("start io_out", io_out, 20'h00001);
    check("start rgb_n", rgb_n, 3'b110);
    for (int t = 1; t <= 92; t++) begin
      one_tick(3);
      if (t == 2)  check("tick2 io_out", io_out, 20'h00002);
      if (t == 38) check("tick38 io_out", io_out, 20'h80000);
      if (t == 40) check("tick40 io_out", io_out, 20'h55555);
      if (t == 42) check("tick42 io_out", io_out, 20'hAAAAA);
      if (t == 44) check("tick44 io_out", io_out, 20'hFFFFF);
      if (t == 44) check("tick44 rgb_n", rgb_n, 3'b011);
      if (t == 46) check("tick46 pass_cnt", pass_cnt, 1);
      if (t == 46) check("tick46 io_out", io_out, 20'h00001);
      if (t == 92) check("tick92 done", done, 1);
      if (t == 92) check("tick92 rgb_n", rgb_n, 3'b000);
      if (t == 92) check("tick92 pass_cnt", pass_cnt, 2);
    end
    drive(1, 0, 0); drive(0, 0, 0);
    for (int t = 0; t < 10; t++) one_tick(3);
    drive(0, 1, 0); drive(0, 0, 0);
    check("abort io_out", io_out, 0);
    check("abort busy", busy, 0);
    check("abort rgb_n", rgb_n, 3'b111);
    check("abort pass_cnt", pass_cnt, 0);
    drive(1, 0, 0); drive(0, 0, 0);
    check("restart io_out", io_out, 20'h00001);
    drive(0, 1, 0); drive(1, 1, 0); drive(0, 0, 0);
    check("start+abort busy", busy, 0);
    drive(1, 0, 0); drive(0, 0, 0);
    for (int t = 0; t < 10; t++) one_tick(1);
    check("pin5 io_out", io_out, 20'h00020);
    drive(1, 0, 0);
    one_tick(1);
    one_tick(1);
    check("busy start ignored", io_out, 20'h00040);
    for (int t = 0; t < 80; t++) drive(0, 0, 1);
    drive(0, 0, 0);
    check("b2b done", done, 1);
    drive(1, 0, 1); drive(0, 0, 0);
    check("done restart io_out", io_out, 20'h00001);
    check("done restart done", done, 0);
    check("done restart pass_cnt", pass_cnt, 0);
    one_tick(1);
    check("first tick holds", io_out, 20'h00001);
    one_tick(1);
    check("second tick steps", io_out, 20'h00002);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      rst   = $urandom_range(0, 799) == 0;
      start = $urandom_range(0, 19) == 0;
      abort = $urandom_range(0, 149) == 0;
      tick  = $urandom_range(0, 1) == 1;
    end
    drive(0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/io_test_sequencer.md
Name: io_test_sequencer

Overview:
- Controller that sequences the board-level IO/LED assembly test. It replaces a free-running walking counter with a start/abort-controlled, multi-phase pattern scheduler.
- Driven by a 1-cycle `tick` strobe from the Hz clock divider's pulse output. Outputs drive the IO header pins and the active-low RGB LED.
- Reports busy, done and the completed pass count so a UART reporter or host logic can sequence repeated runs.

Parameters:
- NUM_PINS, 20: number of IO pins under test (≥2).
- DWELL_TICKS, 1: ticks each pattern step is held (≥1).
- NUM_PASSES, 2: full pattern passes per run (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse; begins a run from IDLE or DONE.
- abort  in  1  1-cycle pulse; terminates a run.
- tick  in  1  1-cycle step strobe from the Hz divider pulse output.
- io_out  out  NUM_PINS  pattern driven onto the IO pins; bit i = pin i, active-high.
- rgb_n  out  3  {blu,grn,red}, active-low.
- busy  out  1  high in WALK/CHECK_A/CHECK_B/ALL_ON.
- done  out  1  high in DONE.
- pass_cnt  out  $clog2(NUM_PASSES+1)  completed passes in the current or last run.

Behaviour:
- Interface decision: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, io_out=0, rgb_n=3'b111, busy=0, done=0, pass_cnt=0, pin index=0, dwell count=0.
- States: IDLE, WALK, CHECK_A, CHECK_B, ALL_ON, DONE. All outputs are registered.
- Step rule: the dwell counter counts ticks only while busy. A step completes on the tick when dwell==DWELL_TICKS-1; the counter then clears.
  - The dwell counter also clears on every state entry and every pin advance.
  - The new pattern appears the cycle after the completing tick.
- IDLE -> WALK: on start. io_out=1<<0 the next cycle and pass_cnt clears to 0. A tick in the same cycle as start is not counted.
- WALK: io_out is one-hot at the pin index.
  - On step: index+1.
  - On step at index NUM_PINS-1: index clears to 0 and the state goes to CHECK_A.
- CHECK_A: io_out = even pins set (…0101). On step -> CHECK_B.
- CHECK_B: io_out = odd pins set (…1010). On step -> ALL_ON.
- ALL_ON: io_out = all ones. On step, pass_cnt+1; then:
  - if the new pass_cnt == NUM_PASSES -> DONE;
  - otherwise -> WALK at index 0.
- DONE: io_out=0, done=1, pass_cnt held. start -> WALK with pass_cnt cleared and done low the next cycle.
- rgb_n by state:
  - IDLE: 111
  - WALK: 110 (red)
  - CHECK_A/CHECK_B: 101 (green)
  - ALL_ON: 011 (blue)
  - DONE: 000 (white)
- Run length: each pass is (NUM_PINS+3)*DWELL_TICKS ticks.
- Boundaries:
  - start while busy: ignored.
  - abort in any state: -> IDLE next cycle with IDLE output values, except pass_cnt, which holds its value.
  - abort beats start and tick in the same cycle.
  - abort in IDLE or DONE: -> IDLE, done=0.
  - rst mid-run: identical to reset values; takes priority over everything.
  - Back-to-back ticks (tick high on consecutive cycles): each counts.

Optional Feature:
- Macro IO_TEST_HOLD_EN.
- Defined: adds input port `hold` (1 bit).
  - While hold=1 and busy, ticks are ignored and the pattern and dwell count freeze.
  - rgb_n=100 (red+green) while held.
  - start and abort behave normally during hold.
- Undefined: no hold port; ticks are always counted while busy.

Decomposition:
- Shared include/package io_test_pkg:
  - state encodings (IDLE=0 … DONE=5);
  - RGB_OFF/RGB_RED/RGB_GRN/RGB_BLU/RGB_WHT/RGB_YEL constants;
  - checker-pattern generation function.
- Sub-module io_test_dwell_timer: tick counter with clear/enable inputs and a 1-cycle `step` output, parameterised by DWELL_TICKS.

Test Plan (NUM_PINS=20, DWELL_TICKS=2, NUM_PASSES=2 unless noted):
- Reset, then idle 50 cycles with ticks -> io_out=0, rgb_n=111, busy=0, done=0, pass_cnt=0.
- start, then tick every 4 cycles -> io_out=0x00001 after start, 0x00002 after 2nd tick, …, 0x80000, 0x55555, 0xAAAAA, 0xFFFFF; pass_cnt=1 after 46 ticks; done=1, rgb_n=000, pass_cnt=2 after 92 ticks.
- abort on the cycle after the 10th tick -> next cycle io_out=0, busy=0, rgb_n=111, pass_cnt=0; a later start restarts at 0x00001.
- start and abort in the same cycle in IDLE -> stays IDLE. start while busy at pin 5 -> no effect, sequence continues.
- DONE then start with a tick in the same cycle -> done=0, io_out=0x00001, pass_cnt=0; the first step needs 2 further ticks.
- IO_TEST_HOLD_EN, hold=1 during pin 7 for 10 ticks -> io_out stays 0x00080, rgb_n=100; after release, 2 ticks advance to 0x00100.
